// File: rtl/reg_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank_arbiter_if
//  Purpose  : Bundles the two requester channels (A and B) and the shared
//             response signals of the register-bank arbiter.
//  Ports    : master - client side: drives req/we/addr/wdata for A and B,
//                      observes grant/ack/rdata/busy/txn_count.
//             slave  - arbiter side: the mirror image of master.
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_bank_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [WIDTH-1:0]  wdata_a;
    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [WIDTH-1:0]  wdata_b;
    logic              grant_a;
    logic              grant_b;
    logic              ack_a;
    logic              ack_b;
    logic [WIDTH-1:0]  rdata;
    logic              busy;
    logic [7:0]        txn_count;

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        input  grant_a, grant_b, ack_a, ack_b, rdata, busy, txn_count
    );

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        output grant_a, grant_b, ack_a, ack_b, rdata, busy, txn_count
    );
endinterface
`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank_arbiter
//  Purpose  : Round-robin arbiter/sequencer sharing a DEPTH x WIDTH flip-flop
//             register bank between requesters A and B. Each grant performs
//             one write or one read and ends with a one-cycle ack.
//  Ports    : clk    - clock, rising edge active
//             rst_n  - asynchronous active-low reset
//             bus    - reg_bank_arbiter_if.slave (requests in, grant/ack/
//                      rdata/busy/txn_count out; all outputs registered)
//  Revision : 1.0 - initial release
// ============================================================================
module reg_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    reg_bank_arbiter_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT_A = 2'd1;
    localparam logic [1:0] S_GRANT_B = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    // 1 when A was served most recently; reset value 0 gives A priority.
    logic              last_a_q;
    logic              grant_a_q;
    logic              grant_b_q;
    logic              ack_a_q;
    logic              ack_b_q;
    logic              busy_q;
    logic [WIDTH-1:0]  rdata_q;
    logic [7:0]        txn_count_q;
    logic [WIDTH-1:0]  bank_q [DEPTH];

    logic              w_access;
    logic              w_owner_we;
    logic [ADDR_W-1:0] w_owner_addr;
    logic [WIDTH-1:0]  w_owner_wdata;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // On contention the requester not served last wins.
                if (bus.req_a && (!bus.req_b || !last_a_q)) begin
                    state_d = S_GRANT_A;
                end else if (bus.req_b) begin
                    state_d = S_GRANT_B;
                end
            end
            S_GRANT_A, S_GRANT_B: state_d = S_DONE;
            S_DONE:               state_d = S_IDLE;
            default:              state_d = S_IDLE;
        endcase
    end

    // Only the current owner's channel reaches the bank; the other is ignored.
    assign w_access      = (state_q == S_GRANT_A) || (state_q == S_GRANT_B);
    assign w_owner_we    = (state_q == S_GRANT_B) ? bus.we_b    : bus.we_a;
    assign w_owner_addr  = (state_q == S_GRANT_B) ? bus.addr_b  : bus.addr_a;
    assign w_owner_wdata = (state_q == S_GRANT_B) ? bus.wdata_b : bus.wdata_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_a_q    <= 1'b0;
            grant_a_q   <= 1'b0;
            grant_b_q   <= 1'b0;
            ack_a_q     <= 1'b0;
            ack_b_q     <= 1'b0;
            busy_q      <= 1'b0;
            rdata_q     <= '0;
            txn_count_q <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            // Grant/busy are registered copies of the next state so they
            // line up exactly with the state they describe.
            grant_a_q <= (state_d == S_GRANT_A);
            grant_b_q <= (state_d == S_GRANT_B);
            busy_q    <= (state_d != S_IDLE);
            ack_a_q   <= (state_q == S_GRANT_A);
            ack_b_q   <= (state_q == S_GRANT_B);
            if (w_access) begin
                if (w_owner_we) begin
                    bank_q[w_owner_addr] <= w_owner_wdata;
                end else begin
                    rdata_q <= bank_q[w_owner_addr];
                end
                last_a_q    <= (state_q == S_GRANT_A);
                txn_count_q <= txn_count_q + 8'd1;
            end
        end
    end

    assign bus.grant_a   = grant_a_q;
    assign bus.grant_b   = grant_b_q;
    assign bus.ack_a     = ack_a_q;
    assign bus.ack_b     = ack_b_q;
    assign bus.busy      = busy_q;
    assign bus.rdata     = rdata_q;
    assign bus.txn_count = txn_count_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_bank_arbiter
//  Purpose  : Directed self-checking bench for reg_bank_arbiter.
//  Ports    : none (top level)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_arbiter;
    logic clk;
    logic rst_n;

    int tests;
    int fails;

    // Per-run logs filled by run_both (0 = A, 1 = B).
    int         gnt_log[$];
    int         gcyc_log[$];
    logic [7:0] cnt_log[$];
    int         ack_cyc_a;
    int         ack_cyc_b;
    logic [7:0] rd_a;
    logic [7:0] rd_b;
    logic       overlap;
    logic       timeout;

    reg_bank_arbiter_if #(.WIDTH(8), .DEPTH(4)) bus ();

    reg_bank_arbiter #(.WIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.req_a   = 1'b0;
        bus.req_b   = 1'b0;
        bus.we_a    = 1'b0;
        bus.we_b    = 1'b0;
        bus.addr_a  = 2'd0;
        bus.addr_b  = 2'd0;
        bus.wdata_a = 8'd0;
        bus.wdata_b = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Drives A for na transactions and B for nb, each client dropping req
    // once its quota of acks has been seen. Logs grants, ack cycles, rdata.
    task automatic run_both(input int na, input logic wa, input logic [1:0] aa,
                            input logic [7:0] da, input int nb, input logic wb,
                            input logic [1:0] ab, input logic [7:0] db);
        int done_a;
        int done_b;
        int cyc;
        done_a = 0;
        done_b = 0;
        cyc    = 0;
        gnt_log.delete();
        gcyc_log.delete();
        cnt_log.delete();
        overlap   = 1'b0;
        timeout   = 1'b0;
        ack_cyc_a = -1;
        ack_cyc_b = -1;
        bus.we_a    = wa;
        bus.addr_a  = aa;
        bus.wdata_a = da;
        bus.we_b    = wb;
        bus.addr_b  = ab;
        bus.wdata_b = db;
        bus.req_a   = (na > 0);
        bus.req_b   = (nb > 0);
        while (((done_a < na) || (done_b < nb)) && !timeout) begin
            tick();
            cyc++;
            if (bus.grant_a) begin gnt_log.push_back(0); gcyc_log.push_back(cyc); end
            if (bus.grant_b) begin gnt_log.push_back(1); gcyc_log.push_back(cyc); end
            if (bus.ack_a && bus.ack_b) overlap = 1'b1;
            if (bus.ack_a) begin
                done_a++;
                ack_cyc_a = cyc;
                rd_a = bus.rdata;
                cnt_log.push_back(bus.txn_count);
            end
            if (bus.ack_b) begin
                done_b++;
                ack_cyc_b = cyc;
                rd_b = bus.rdata;
                cnt_log.push_back(bus.txn_count);
            end
            bus.req_a = (done_a < na);
            bus.req_b = (done_b < nb);
            if (cyc > 3 * (na + nb) + 10) timeout = 1'b1;
        end
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        // Dirty the bank and rdata first so the reset has something to clear.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_both(1, 1'b1, 2'(i), 8'h5A ^ 8'(i), 0, 1'b0, 2'd0, 8'd0);
        end
        run_both(1, 1'b0, 2'd1, 8'd0, 0, 1'b0, 2'd0, 8'd0);
        do_reset();
        tests++;
        if ({bus.grant_a, bus.grant_b, bus.ack_a, bus.ack_b, bus.busy} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {bus.grant_a, bus.grant_b, bus.ack_a, bus.ack_b, bus.busy});
        end
        tests++;
        if (bus.txn_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_count: got %0d want 0", bus.txn_count);
        end
        tests++;
        if (bus.rdata !== 8'h00) begin
            fails++;
            $display("FAIL reset_rdata: got %h want 00", bus.rdata);
        end
        for (int i = 0; i < 4; i++) begin
            run_both(1, 1'b0, 2'(i), 8'd0, 0, 1'b0, 2'd0, 8'd0);
            tests++;
            if (timeout || rd_a !== 8'h00) begin
                fails++;
                $display("FAIL reset_bank[%0d]: got %h timeout=%b want 00", i, rd_a, timeout);
            end
        end
    endtask

    task automatic test_write_read();
        do_reset();
        run_both(1, 1'b1, 2'd2, 8'hA5, 0, 1'b0, 2'd0, 8'd0);
        tests++;
        if (ack_cyc_a !== 2) begin
            fails++;
            $display("FAIL wr_latency: got %0d want 2", ack_cyc_a);
        end
        tests++;
        if (bus.ack_a !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL wr_ack_pulse: ack_a=%b busy=%b want 0 0", bus.ack_a, bus.busy);
        end
        run_both(1, 1'b0, 2'd2, 8'd0, 0, 1'b0, 2'd0, 8'd0);
        tests++;
        if (ack_cyc_a !== 2 || gcyc_log.size() !== 1 || gcyc_log[0] !== 1) begin
            fails++;
            $display("FAIL rd_timing: ack_cyc=%0d grants=%0d want ack 2 grant at 1",
                     ack_cyc_a, gcyc_log.size());
        end
        tests++;
        if (rd_a !== 8'hA5) begin
            fails++;
            $display("FAIL rd_data: got %h want a5", rd_a);
        end
        tests++;
        if (bus.txn_count !== 8'd2) begin
            fails++;
            $display("FAIL wr_rd_count: got %0d want 2", bus.txn_count);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        run_both(1, 1'b1, 2'd0, 8'h11, 1, 1'b1, 2'd1, 8'h22);
        tests++;
        if (timeout || gnt_log.size() !== 2 || gnt_log[0] !== 0 || gnt_log[1] !== 1) begin
            fails++;
            $display("FAIL sim_order: n=%0d first=%0d want A then B",
                     gnt_log.size(), (gnt_log.size() > 0) ? gnt_log[0] : -1);
        end
        tests++;
        if (gcyc_log.size() !== 2 || gcyc_log[0] !== 1 || gcyc_log[1] !== 4) begin
            fails++;
            $display("FAIL sim_spacing: grant cycles %0d,%0d want 1,4",
                     (gcyc_log.size() > 0) ? gcyc_log[0] : -1,
                     (gcyc_log.size() > 1) ? gcyc_log[1] : -1);
        end
        tests++;
        if (overlap !== 1'b0) begin
            fails++;
            $display("FAIL sim_ack_overlap: got %b want 0", overlap);
        end
        run_both(1, 1'b0, 2'd0, 8'd0, 1, 1'b0, 2'd1, 8'd0);
        tests++;
        if (rd_a !== 8'h11 || rd_b !== 8'h22) begin
            fails++;
            $display("FAIL sim_readback: got %h %h want 11 22", rd_a, rd_b);
        end
    endtask

    task automatic test_fairness();
        int repeats;
        do_reset();
        run_both(6, 1'b1, 2'd0, 8'h33, 6, 1'b1, 2'd1, 8'h44);
        repeats = 0;
        for (int i = 0; i < gnt_log.size(); i++) begin
            if (gnt_log[i] !== (i % 2)) repeats++;
        end
        tests++;
        if (timeout || gnt_log.size() !== 12 || repeats !== 0) begin
            fails++;
            $display("FAIL fair_alternation: grants=%0d out_of_order=%0d want 12 0",
                     gnt_log.size(), repeats);
        end
        tests++;
        if (bus.txn_count !== 8'd12) begin
            fails++;
            $display("FAIL fair_count: got %0d want 12", bus.txn_count);
        end
    endtask

    task automatic test_reset_mid_txn();
        logic saw_ack;
        do_reset();
        // Serve A once so that, without a reset, priority would point at B.
        run_both(1, 1'b1, 2'd0, 8'h77, 0, 1'b0, 2'd0, 8'd0);
        bus.we_b    = 1'b1;
        bus.addr_b  = 2'd3;
        bus.wdata_b = 8'hFF;
        bus.req_b   = 1'b1;
        tick();
        tests++;
        if (bus.grant_b !== 1'b1) begin
            fails++;
            $display("FAIL mid_grant_b: got %b want 1", bus.grant_b);
        end
        rst_n     = 1'b0;
        bus.req_b = 1'b0;
        #1;
        tests++;
        if (bus.grant_b !== 1'b0 || bus.busy !== 1'b0 || bus.txn_count !== 8'd0) begin
            fails++;
            $display("FAIL mid_async_clear: grant_b=%b busy=%b count=%0d want 0 0 0",
                     bus.grant_b, bus.busy, bus.txn_count);
        end
        saw_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.ack_b) saw_ack = 1'b1;
            if (i == 1) rst_n = 1'b1;
        end
        tests++;
        if (saw_ack !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_no_ack: ack_b_seen=%b busy=%b want 0 0", saw_ack, bus.busy);
        end
        run_both(1, 1'b0, 2'd3, 8'd0, 1, 1'b0, 2'd0, 8'd0);
        tests++;
        if (gnt_log.size() !== 2 || gnt_log[0] !== 0) begin
            fails++;
            $display("FAIL mid_prio: first=%0d want 0 (A)",
                     (gnt_log.size() > 0) ? gnt_log[0] : -1);
        end
        tests++;
        if (rd_a !== 8'h00 || rd_b !== 8'h00) begin
            fails++;
            $display("FAIL mid_bank: addr3=%h addr0=%h want 00 00", rd_a, rd_b);
        end
    endtask

    task automatic test_count_wrap();
        int repeats;
        do_reset();
        run_both(128, 1'b1, 2'd0, 8'h01, 127, 1'b1, 2'd1, 8'h02);
        repeats = 0;
        for (int i = 0; i < gnt_log.size(); i++) begin
            if (gnt_log[i] !== (i % 2)) repeats++;
        end
        tests++;
        if (timeout || bus.txn_count !== 8'd255 || repeats !== 0) begin
            fails++;
            $display("FAIL wrap_255: count=%0d out_of_order=%0d timeout=%b want 255 0 0",
                     bus.txn_count, repeats, timeout);
        end
        // Last served was A, so B must win the next contention.
        run_both(1, 1'b0, 2'd1, 8'd0, 1, 1'b0, 2'd0, 8'd0);
        tests++;
        if (cnt_log.size() !== 2 || cnt_log[0] !== 8'd0 || cnt_log[1] !== 8'd1) begin
            fails++;
            $display("FAIL wrap_0_1: got %0d,%0d want 0,1",
                     (cnt_log.size() > 0) ? cnt_log[0] : 8'hxx,
                     (cnt_log.size() > 1) ? cnt_log[1] : 8'hxx);
        end
        tests++;
        if (gnt_log.size() !== 2 || gnt_log[0] !== 1 || gnt_log[1] !== 0) begin
            fails++;
            $display("FAIL wrap_arb: first=%0d want 1 (B) then A",
                     (gnt_log.size() > 0) ? gnt_log[0] : -1);
        end
        tests++;
        if (rd_a !== 8'h02 || rd_b !== 8'h01) begin
            fails++;
            $display("FAIL wrap_data: addr1=%h addr0=%h want 02 01", rd_a, rd_b);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_write_read();
        test_simultaneous();
        test_fairness();
        test_reset_mid_txn();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
